// File: rtl/vram_dma_pkg.sv
// rtl/vram_dma_pkg.sv - register map, control/status bits and FSM encoding for vram_dma
package vram_dma_pkg;

  localparam logic [2:0] REG_SRC_L  = 3'd0;
  localparam logic [2:0] REG_SRC_H  = 3'd1;
  localparam logic [2:0] REG_DST_L  = 3'd2;
  localparam logic [2:0] REG_DST_H  = 3'd3;
  localparam logic [2:0] REG_LEN_L  = 3'd4;
  localparam logic [2:0] REG_LEN_H  = 3'd5;
  localparam logic [2:0] REG_CTRL   = 3'd6;
  localparam logic [2:0] REG_STATUS = 3'd7;

  localparam int CTRL_START = 0;
  localparam int CTRL_VSYNC = 1;
  localparam int CTRL_FILL  = 2;
  localparam int CTRL_ABORT = 3;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_REQ,
    S_READ,
    S_CAPT,
    S_WRITE,
    S_RELEASE
  } state_t;

endpackage

// File: rtl/vram_dma_edge_rise.sv
// rtl/vram_dma_edge_rise.sv - registered rising-edge detector (used for vblank)
module edge_rise (
  input  logic clk_24,
  input  logic reset,
  input  logic sig,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk_24 or posedge reset) begin
    if (reset) prev <= 1'b0;
    else       prev <= sig;
  end

  assign rise = sig & ~prev;

endmodule

// File: rtl/vram_dma.sv
// rtl/vram_dma.sv - bus-mastering block-copy engine with optional vblank-synchronised start
module vram_dma
  import vram_dma_pkg::*;
#(
  parameter int LEN_W = 12
) (
  input  logic        clk_24,
  input  logic        reset,
  input  logic        reg_cs,
  input  logic        reg_wr,
  input  logic [2:0]  reg_addr,
  input  logic [7:0]  reg_din,
  output logic [7:0]  reg_dout,
  input  logic        vblank,
  output logic        bus_req,
  input  logic        bus_ack,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic        done
);

  state_t state, state_nx;

  logic [15:0]      src, dst;
  logic [LEN_W-1:0] len;
  logic [15:0]      len_ext;
  logic [7:0]       data;
  logic             fill, abort_pend, done_sticky, done_zero;
  logic             busy, reg_we, ctrl_wr, start, abort, abort_any, vb_rise;

  edge_rise u_vb_rise (
    .clk_24 (clk_24),
    .reset  (reset),
    .sig    (vblank),
    .rise   (vb_rise)
  );

  assign busy      = (state != S_IDLE);
  assign reg_we    = reg_cs & reg_wr;
  assign ctrl_wr   = reg_we & (reg_addr == REG_CTRL);
  assign start     = ctrl_wr & reg_din[CTRL_START];
  assign abort     = ctrl_wr & reg_din[CTRL_ABORT];
  assign abort_any = abort | abort_pend;
  assign len_ext   = 16'(len);

  always_ff @(posedge clk_24 or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // An abort during READ/CAPT still lets the current byte reach WRITE.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (start && len != '0)
          state_nx = reg_din[CTRL_VSYNC] ? S_SYNC : S_REQ;
      end
      S_SYNC: begin
        if (abort_any)    state_nx = S_RELEASE;
        else if (vb_rise) state_nx = S_REQ;
      end
      S_REQ: begin
        if (abort_any)    state_nx = S_RELEASE;
        else if (bus_ack) state_nx = S_READ;
      end
      S_READ:  state_nx = S_CAPT;
      S_CAPT:  state_nx = S_WRITE;
      S_WRITE: begin
        if (abort_any || len == LEN_W'(1)) state_nx = S_RELEASE;
        else                                state_nx = S_READ;
      end
      S_RELEASE: state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_24 or posedge reset) begin
    if (reset) begin
      src         <= 16'h0000;
      dst         <= 16'h0000;
      len         <= '0;
      data        <= 8'h00;
      fill        <= 1'b0;
      abort_pend  <= 1'b0;
      done_sticky <= 1'b0;
      done_zero   <= 1'b0;
    end else begin
      done_zero <= 1'b0;

      if (reg_we && !busy) begin
        case (reg_addr)
          REG_SRC_L: src[7:0]  <= reg_din;
          REG_SRC_H: src[15:8] <= reg_din;
          REG_DST_L: dst[7:0]  <= reg_din;
          REG_DST_H: dst[15:8] <= reg_din;
          REG_LEN_L: len       <= LEN_W'({len_ext[15:8], reg_din});
          REG_LEN_H: len       <= LEN_W'({reg_din, len_ext[7:0]});
          default: ;
        endcase
      end

      if (ctrl_wr) done_sticky <= 1'b0;

      if (start && !busy) begin
        fill <= reg_din[CTRL_FILL];
        if (len == '0) begin
          done_sticky <= 1'b1;
          done_zero   <= 1'b1;
        end
      end

      if (state == S_IDLE || state == S_RELEASE) abort_pend <= 1'b0;
      else if (abort)                            abort_pend <= 1'b1;

      if (state == S_CAPT) data <= mem_din;

      if (state == S_WRITE) begin
        dst <= dst + 16'd1;
        if (!fill) src <= src + 16'd1;
        len <= len - LEN_W'(1);
      end

      if (state == S_RELEASE) done_sticky <= 1'b1;
    end
  end

  // Bus outputs decode straight from the state register so reset drops them at once.
  always_comb begin
    bus_req  = (state == S_REQ) || (state == S_READ) || (state == S_CAPT) || (state == S_WRITE);
    mem_rd   = (state == S_READ) || (state == S_CAPT);
    mem_wr   = (state == S_WRITE);
    mem_addr = mem_wr ? dst : (mem_rd ? src : 16'h0000);
    mem_dout = mem_wr ? data : 8'h00;
    done     = (state == S_RELEASE) || done_zero;
  end

  always_comb begin
    reg_dout = 8'h00;
    case (reg_addr)
      REG_SRC_L:  reg_dout = src[7:0];
      REG_SRC_H:  reg_dout = src[15:8];
      REG_DST_L:  reg_dout = dst[7:0];
      REG_DST_H:  reg_dout = dst[15:8];
      REG_LEN_L:  reg_dout = len_ext[7:0];
      REG_LEN_H:  reg_dout = len_ext[15:8];
      REG_STATUS: begin
        reg_dout[STAT_BUSY] = busy;
        reg_dout[STAT_DONE] = done_sticky;
      end
      default:    reg_dout = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_vram_dma.sv
// tb/tb_vram_dma.sv - directed self-checking bench for vram_dma
module tb_vram_dma;

  logic        clk_24 = 1'b0;
  logic        reset;
  logic        reg_cs, reg_wr;
  logic [2:0]  reg_addr;
  logic [7:0]  reg_din, reg_dout;
  logic        vblank;
  logic        bus_req, bus_ack;
  logic [15:0] mem_addr;
  logic        mem_rd, mem_wr;
  logic [7:0]  mem_din, mem_dout;
  logic        done;

  int checks = 0;
  int failures = 0;

  vram_dma #(.LEN_W(12)) dut (
    .clk_24   (clk_24),
    .reset    (reset),
    .reg_cs   (reg_cs),
    .reg_wr   (reg_wr),
    .reg_addr (reg_addr),
    .reg_din  (reg_din),
    .reg_dout (reg_dout),
    .vblank   (vblank),
    .bus_req  (bus_req),
    .bus_ack  (bus_ack),
    .mem_addr (mem_addr),
    .mem_rd   (mem_rd),
    .mem_wr   (mem_wr),
    .mem_din  (mem_din),
    .mem_dout (mem_dout),
    .done     (done)
  );

  always #21 clk_24 = ~clk_24;

  logic [7:0]  mem [0:65535];
  logic [15:0] wa_q[$];
  logic [7:0]  wd_q[$];
  logic [15:0] ra_q[$];
  int cyc = 0, done_cnt = 0, done_cyc = 0, first_rd_cyc = 0, ack_cnt = 0;
  logic rd_prev = 1'b0, ack_prev = 1'b0, req_seen = 1'b0;

  // Bus arbiter grants two negedges after the request; memory answers on negedges.
  always @(negedge clk_24) begin
    if (bus_req) begin
      if (ack_cnt < 2) ack_cnt++;
      bus_ack = (ack_cnt >= 2);
    end else begin
      ack_cnt = 0;
      bus_ack = 1'b0;
    end
    if (mem_rd) begin
      mem_din = mem[mem_addr];
      if (!rd_prev) begin
        if (ra_q.size() == 0) first_rd_cyc = cyc;
        ra_q.push_back(mem_addr);
      end
    end
    rd_prev = mem_rd;
    if (mem_wr) begin
      mem[mem_addr] = mem_dout;
      wa_q.push_back(mem_addr);
      wd_q.push_back(mem_dout);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  always @(posedge clk_24) begin
    cyc++;
    if (bus_req) req_seen = 1'b1;
    if (ack_prev && !bus_ack && bus_req) begin
      failures++;
      $error("FAIL bus_ack_drop: bus_ack fell while bus_req=%0b", bus_req);
    end
    ack_prev = bus_ack;
  end

  task automatic tick;
    @(negedge clk_24);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [7:0] d);
    reg_cs = 1'b1; reg_wr = 1'b1; reg_addr = a; reg_din = d;
    tick;
    reg_cs = 1'b0; reg_wr = 1'b0; reg_din = 8'h00;
  endtask

  task automatic rd_reg(input logic [2:0] a, output logic [7:0] d);
    reg_addr = a;
    #1;
    d = reg_dout;
  endtask

  task automatic prog(input logic [15:0] s, input logic [15:0] dd, input logic [15:0] l);
    wr_reg(3'd0, s[7:0]);  wr_reg(3'd1, s[15:8]);
    wr_reg(3'd2, dd[7:0]); wr_reg(3'd3, dd[15:8]);
    wr_reg(3'd4, l[7:0]);  wr_reg(3'd5, l[15:8]);
    wa_q.delete(); wd_q.delete(); ra_q.delete();
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < budget && done_cnt == d0; i++) tick;
    check(tag, done_cnt, d0 + 1);
    tick;
  endtask

  logic [7:0] rv;
  logic [7:0] exp_d [4];
  int n;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    reset = 1'b1; reg_cs = 1'b0; reg_wr = 1'b0; reg_addr = 3'd0; reg_din = 8'h00;
    vblank = 1'b0; bus_ack = 1'b0; mem_din = 8'h00;
    tick;
    check("rst_outputs", {bus_req, mem_rd, mem_wr, done, mem_addr, mem_dout}, 32'h0);
    tick;
    reset = 1'b0;
    tick;
    for (int a = 0; a < 8; a++) begin
      rd_reg(3'(a), rv);
      check($sformatf("rst_reg%0d", a), rv, 8'h00);
    end

    // basic 4-byte copy
    exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33; exp_d[3] = 8'h44;
    for (int i = 0; i < 4; i++) mem[16'hC000 + i] = exp_d[i];
    prog(16'hC000, 16'h9800, 16'd4);
    wr_reg(3'd6, 8'h01);
    check("t1_req_next", bus_req, 1'b1);
    wait_done("t1_done", 200);
    check("t1_nwr", wa_q.size(), 4);
    check("t1_nrd", ra_q.size(), 4);
    if (wa_q.size() == 4 && ra_q.size() == 4)
      for (int i = 0; i < 4; i++) begin
        check($sformatf("t1_wa%0d", i), wa_q[i], 32'h9800 + i);
        check($sformatf("t1_wd%0d", i), wd_q[i], exp_d[i]);
        check($sformatf("t1_ra%0d", i), ra_q[i], 32'hC000 + i);
      end
    check("t1_done_lat", done_cyc - first_rd_cyc, 12);
    rd_reg(3'd7, rv); check("t1_status", rv, 8'h02);
    rd_reg(3'd2, rv); check("t1_dst_l", rv, 8'h04);
    rd_reg(3'd4, rv); check("t1_len_l", rv, 8'h00);

    // fill mode
    mem[16'hC010] = 8'h5A; mem[16'hC011] = 8'h77;
    prog(16'hC010, 16'hA000, 16'd3);
    wr_reg(3'd6, 8'h05);
    wait_done("t2_done", 200);
    check("t2_nwr", wa_q.size(), 3);
    if (wa_q.size() == 3)
      for (int i = 0; i < 3; i++) begin
        check($sformatf("t2_wa%0d", i), wa_q[i], 32'hA000 + i);
        check($sformatf("t2_wd%0d", i), wd_q[i], 8'h5A);
      end
    rd_reg(3'd0, rv); check("t2_src_l", rv, 8'h10);
    rd_reg(3'd1, rv); check("t2_src_h", rv, 8'hC0);

    // vsync start with vblank already high
    vblank = 1'b1;
    tick;
    prog(16'hC000, 16'h8000, 16'd1);
    wr_reg(3'd6, 8'h03);
    check("t3_sync_req0", bus_req, 1'b0);
    repeat (3) tick;
    check("t3_high_req0", bus_req, 1'b0);
    rd_reg(3'd7, rv); check("t3_busy", rv, 8'h01);
    vblank = 1'b0;
    repeat (3) tick;
    check("t3_low_req0", bus_req, 1'b0);
    vblank = 1'b1;
    check("t3_edge_req0", bus_req, 1'b0);
    tick;
    check("t3_edge_req1", bus_req, 1'b1);
    wait_done("t3_done", 200);
    check("t3_wd", (wd_q.size() == 1) ? wd_q[0] : 8'hxx, 8'h11);
    vblank = 1'b0;

    // destination wrap, then zero length
    prog(16'hC000, 16'hFFFF, 16'd2);
    wr_reg(3'd6, 8'h01);
    wait_done("t4_done", 200);
    check("t4_nwr", wa_q.size(), 2);
    if (wa_q.size() == 2) begin
      check("t4_wa0", wa_q[0], 16'hFFFF);
      check("t4_wa1", wa_q[1], 16'h0000);
      check("t4_wd1", wd_q[1], 8'h22);
    end
    rd_reg(3'd2, rv); check("t4_dst_l", rv, 8'h01);
    rd_reg(3'd3, rv); check("t4_dst_h", rv, 8'h00);
    wr_reg(3'd6, 8'h00);
    rd_reg(3'd7, rv); check("t4_sticky_clr", rv, 8'h00);
    prog(16'hC000, 16'h9000, 16'd0);
    req_seen = 1'b0;
    n = done_cnt;
    wr_reg(3'd6, 8'h01);
    check("t4_zero_done", done_cnt, n + 1);
    repeat (4) tick;
    check("t4_zero_pulse1", done_cnt, n + 1);
    check("t4_zero_noreq", req_seen, 1'b0);
    rd_reg(3'd7, rv); check("t4_zero_status", rv, 8'h02);

    // abort in CAPT of byte 2 of 5
    prog(16'hC000, 16'hB000, 16'd5);
    wr_reg(3'd6, 8'h01);
    for (int i = 0; i < 100 && ra_q.size() < 2; i++) tick;
    check("t5_reach_rd2", ra_q.size(), 2);
    tick;
    check("t5_capt_rd", mem_rd, 1'b1);
    wr_reg(3'd6, 8'h08);
    wait_done("t5_done", 50);
    check("t5_nwr", wa_q.size(), 2);
    if (wa_q.size() == 2) begin
      check("t5_wa1", wa_q[1], 16'hB001);
      check("t5_wd1", wd_q[1], 8'h22);
    end
    rd_reg(3'd4, rv); check("t5_len_l", rv, 8'h03);
    rd_reg(3'd7, rv); check("t5_status", rv, 8'h02);

    // reset during WRITE
    prog(16'hC000, 16'hC800, 16'd3);
    wr_reg(3'd6, 8'h01);
    for (int i = 0; i < 100 && mem_wr !== 1'b1; i++) tick;
    check("t6_in_write", mem_wr, 1'b1);
    n = wa_q.size();
    reset = 1'b1;
    #1;
    check("t6_async_wr", mem_wr, 1'b0);
    check("t6_async_req", bus_req, 1'b0);
    repeat (2) tick;
    reset = 1'b0;
    repeat (2) tick;
    for (int a = 0; a < 8; a++) begin
      rd_reg(3'(a), rv);
      check($sformatf("t6_reg%0d", a), rv, 8'h00);
    end
    check("t6_no_more_wr", wa_q.size(), n);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
